// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package data_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        WRITE_WAIT = 2'd2,
        RELAY      = 2'd3
    } arb_state_t;

    // Width of a consumer index; a single consumer still needs one bit.
    function automatic int grant_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundles the per-consumer LSU channels and the shared memory port.
// master: the arbiter's view; slave: the consumers/memory side.
interface data_mem_arbiter_if #(
    parameter int NUM_CONSUMERS = 8,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8
);
    // consumer side
    logic [NUM_CONSUMERS-1:0]                consumer_read_request;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;
    logic [NUM_CONSUMERS-1:0]                consumer_write_request;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data;
    logic [NUM_CONSUMERS-1:0]                consumer_write_ready;
    // memory side
    logic                 mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic                 mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data;
    logic                 mem_write_valid;
    logic [ADDR_BITS-1:0] mem_write_address;
    logic [DATA_BITS-1:0] mem_write_data;
    logic                 mem_write_ready;

    modport master (
        input  consumer_read_request, consumer_read_address,
        output consumer_read_ready, consumer_read_data,
        input  consumer_write_request, consumer_write_address, consumer_write_data,
        output consumer_write_ready,
        output mem_read_valid, mem_read_address,
        input  mem_read_ready, mem_read_data,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_write_ready
    );

    modport slave (
        output consumer_read_request, consumer_read_address,
        input  consumer_read_ready, consumer_read_data,
        output consumer_write_request, consumer_write_address, consumer_write_data,
        input  consumer_write_ready,
        input  mem_read_valid, mem_read_address,
        output mem_read_ready, mem_read_data,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_write_ready
    );

endinterface

// File: rtl/data_mem_arbiter_rr_picker.sv
// Rotating priority encoder: first set bit of req at or after ptr, wrapping.
module rr_picker
    import data_mem_arb_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = grant_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    // base + off modulo N; both operands are below N so one subtract suffices
    function automatic logic [IDX_W-1:0] rotate(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N) sum = sum - N;
        return IDX_W'(sum);
    endfunction

    // scan from ptr upward and keep the first requester found
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = rotate(ptr, i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among per-thread LSU
// channels; one transaction in flight, all outputs registered.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int NUM_CONSUMERS = 8,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8
) (
    input  logic                clk,
    input  logic                reset,
    data_mem_arbiter_if.master  bus,
    output logic                busy
);

    localparam int IDX_W = grant_width(NUM_CONSUMERS);

    arb_state_t       state, state_next;
    logic [IDX_W-1:0] grant, grant_next;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_next;
    logic             grant_is_read, grant_is_read_next;

    logic [NUM_CONSUMERS-1:0] any_req;
    logic                     pick_found;
    logic [IDX_W-1:0]         pick_idx;
    logic                     granted_req_held;

    logic                                    rd_valid_d, wr_valid_d;
    logic [ADDR_BITS-1:0]                    rd_addr_d, wr_addr_d;
    logic [DATA_BITS-1:0]                    wr_data_d;
    logic [NUM_CONSUMERS-1:0]                rd_ready_d, wr_ready_d;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] rd_data_d;

    assign any_req = bus.consumer_read_request | bus.consumer_write_request;

    // The request that earned the current grant; RELAY waits for it to drop.
    assign granted_req_held = grant_is_read ? bus.consumer_read_request[grant]
                                            : bus.consumer_write_request[grant];

    rr_picker #(
        .N     (NUM_CONSUMERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (any_req),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // state register plus grant bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            grant         <= '0;
            rr_ptr        <= '0;
            grant_is_read <= 1'b0;
        end else begin
            state         <= state_next;
            grant         <= grant_next;
            rr_ptr        <= rr_ptr_next;
            grant_is_read <= grant_is_read_next;
        end
    end

    // next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pick_found)
                    state_next = bus.consumer_read_request[pick_idx] ? READ_WAIT : WRITE_WAIT;
            end
            READ_WAIT:  if (bus.mem_read_ready)  state_next = RELAY;
            WRITE_WAIT: if (bus.mem_write_ready) state_next = RELAY;
            RELAY:      if (!granted_req_held)   state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // next values for the registered outputs and grant bookkeeping
    always_comb begin
        grant_next         = grant;
        rr_ptr_next        = rr_ptr;
        grant_is_read_next = grant_is_read;
        rd_valid_d         = bus.mem_read_valid;
        wr_valid_d         = bus.mem_write_valid;
        rd_addr_d          = bus.mem_read_address;
        wr_addr_d          = bus.mem_write_address;
        wr_data_d          = bus.mem_write_data;
        rd_ready_d         = bus.consumer_read_ready;
        wr_ready_d         = bus.consumer_write_ready;
        rd_data_d          = bus.consumer_read_data;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_next = pick_idx;
                    // a read beats a simultaneous write from the same consumer
                    if (bus.consumer_read_request[pick_idx]) begin
                        grant_is_read_next = 1'b1;
                        rd_valid_d         = 1'b1;
                        rd_addr_d          = bus.consumer_read_address[pick_idx];
                    end else begin
                        grant_is_read_next = 1'b0;
                        wr_valid_d         = 1'b1;
                        wr_addr_d          = bus.consumer_write_address[pick_idx];
                        wr_data_d          = bus.consumer_write_data[pick_idx];
                    end
                end
            end
            READ_WAIT: begin
                if (bus.mem_read_ready) begin
                    rd_valid_d         = 1'b0;
                    rd_data_d[grant]   = bus.mem_read_data;
                    rd_ready_d[grant]  = 1'b1;
                end
            end
            WRITE_WAIT: begin
                if (bus.mem_write_ready) begin
                    wr_valid_d        = 1'b0;
                    wr_ready_d[grant] = 1'b1;
                end
            end
            RELAY: begin
                if (!granted_req_held) begin
                    rd_ready_d  = '0;
                    wr_ready_d  = '0;
                    rr_ptr_next = (grant == IDX_W'(NUM_CONSUMERS - 1)) ? '0 : grant + IDX_W'(1);
                end
            end
            default: ;
        endcase
    end

    // output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.mem_read_valid       <= 1'b0;
            bus.mem_write_valid      <= 1'b0;
            bus.mem_read_address     <= '0;
            bus.mem_write_address    <= '0;
            bus.mem_write_data       <= '0;
            bus.consumer_read_ready  <= '0;
            bus.consumer_write_ready <= '0;
            bus.consumer_read_data   <= '0;
            busy                     <= 1'b0;
        end else begin
            bus.mem_read_valid       <= rd_valid_d;
            bus.mem_write_valid      <= wr_valid_d;
            bus.mem_read_address     <= rd_addr_d;
            bus.mem_write_address    <= wr_addr_d;
            bus.mem_write_data       <= wr_data_d;
            bus.consumer_read_ready  <= rd_ready_d;
            bus.consumer_write_ready <= wr_ready_d;
            bus.consumer_read_data   <= rd_data_d;
            busy                     <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: stimulus pushes expected completions,
// a monitor pops and compares whenever a consumer ready bit rises.
module tb_data_mem_arbiter;

    localparam int N  = 8;
    localparam int AB = 8;
    localparam int DB = 8;

    logic clk = 1'b0;
    logic reset;
    logic busy;

    always #5 clk = ~clk;

    data_mem_arbiter_if #(.NUM_CONSUMERS(N), .ADDR_BITS(AB), .DATA_BITS(DB)) bus();

    data_mem_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(AB), .DATA_BITS(DB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    typedef struct {
        logic       is_read;
        int         id;
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // memory model state
    logic [7:0] mem [256];
    int         mem_lat = 2;
    logic [7:0] last_rd_addr, last_wr_addr, last_wr_data;
    int         rd_count = 0;
    int         wr_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic is_read, input int id, input logic [7:0] addr, input logic [7:0] data);
        exp_t e;
        e.is_read = is_read;
        e.id      = id;
        e.addr    = addr;
        e.data    = data;
        sb.push_back(e);
    endtask

    // Memory model: contents are a ^ 0xFF except a few directed locations
    initial begin
        int rcnt = 0;
        int wcnt = 0;
        for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'hFF;
        mem[8'h10] = 8'hA5;
        for (int i = 0; i < 9; i++) mem[8'h40 + i] = 8'(8'h80 + i);
        bus.mem_read_ready  = 1'b0;
        bus.mem_read_data   = '0;
        bus.mem_write_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_read_ready) begin
                bus.mem_read_ready = 1'b0;
                rcnt = 0;
            end else if (bus.mem_read_valid) begin
                rcnt++;
                if (rcnt >= mem_lat) begin
                    bus.mem_read_ready = 1'b1;
                    bus.mem_read_data  = mem[bus.mem_read_address];
                    last_rd_addr       = bus.mem_read_address;
                    rd_count++;
                    rcnt = 0;
                end
            end else begin
                rcnt = 0;
            end
            if (bus.mem_write_ready) begin
                bus.mem_write_ready = 1'b0;
                wcnt = 0;
            end else if (bus.mem_write_valid) begin
                wcnt++;
                if (wcnt >= mem_lat) begin
                    bus.mem_write_ready           = 1'b1;
                    mem[bus.mem_write_address]    = bus.mem_write_data;
                    last_wr_addr                  = bus.mem_write_address;
                    last_wr_data                  = bus.mem_write_data;
                    wr_count++;
                    wcnt = 0;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Monitor: protocol invariants every cycle, scoreboard pop on each new completion
    initial begin
        logic prev_any = 1'b0;
        logic any;
        logic is_read;
        int   id;
        exp_t e;
        forever begin
            @(negedge clk);
            check("both_valid", 32'(bus.mem_read_valid & bus.mem_write_valid), 0);
            check("ready_onehot", 32'($onehot0({bus.consumer_read_ready, bus.consumer_write_ready})), 1);
            any = (|bus.consumer_read_ready) | (|bus.consumer_write_ready);
            if (any && !prev_any) begin
                is_read = |bus.consumer_read_ready;
                id = -1;
                for (int i = 0; i < N; i++)
                    if (bus.consumer_read_ready[i] || bus.consumer_write_ready[i]) id = i;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: completion from consumer %0d read=%0b, expected none", id, is_read);
                end else begin
                    e = sb.pop_front();
                    check("sb_kind", 32'(is_read), 32'(e.is_read));
                    check("sb_id", id, e.id);
                    if (e.is_read) begin
                        check("sb_rd_addr", 32'(last_rd_addr), 32'(e.addr));
                        check("sb_rd_data", 32'(bus.consumer_read_data[id]), 32'(e.data));
                    end else begin
                        check("sb_wr_addr", 32'(last_wr_addr), 32'(e.addr));
                        check("sb_wr_data", 32'(last_wr_data), 32'(e.data));
                    end
                end
            end
            prev_any = any;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one cycle, with every served consumer dropping its request
    task automatic step_auto(output logic [N-1:0] dropped);
        @(posedge clk);
        #1;
        dropped = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.consumer_read_ready[i] && bus.consumer_read_request[i]) begin
                bus.consumer_read_request[i] = 1'b0;
                dropped[i] = 1'b1;
            end
            if (bus.consumer_write_ready[i] && bus.consumer_write_request[i]) begin
                bus.consumer_write_request[i] = 1'b0;
                dropped[i] = 1'b1;
            end
        end
    endtask

    function automatic logic all_quiet();
        return (busy == 1'b0) &&
               ((bus.consumer_read_request | bus.consumer_write_request) == '0);
    endfunction

    task automatic run_until_idle(input string name, input int max_cycles);
        logic [N-1:0] d;
        int n = 0;
        do begin
            step_auto(d);
            n++;
        end while (!all_quiet() && n < max_cycles);
        if (!all_quiet()) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
        end
    endtask

    task automatic wait_ready(input string name, input int id, input logic is_read, input int max_cycles);
        int n = 0;
        while (!(is_read ? bus.consumer_read_ready[id] : bus.consumer_write_ready[id]) && n < max_cycles) begin
            step();
            n++;
        end
        check(name, 32'(is_read ? bus.consumer_read_ready[id] : bus.consumer_write_ready[id]), 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.consumer_read_request  = '0;
        bus.consumer_write_request = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [N-1:0] d;
        logic         rearmed, rearm_pending;
        int           rc, n;

        bus.consumer_read_request  = '0;
        bus.consumer_read_address  = '0;
        bus.consumer_write_request = '0;
        bus.consumer_write_address = '0;
        bus.consumer_write_data    = '0;

        // reset state
        do_reset();
        check("rst_busy", 32'(busy), 0);
        check("rst_rd_valid", 32'(bus.mem_read_valid), 0);
        check("rst_wr_valid", 32'(bus.mem_write_valid), 0);
        check("rst_ready", 32'({bus.consumer_read_ready, bus.consumer_write_ready}), 0);
        check("rst_rd_data", 32'(|bus.consumer_read_data), 0);
        step();
        step();
        check("idle_busy", 32'(busy), 0);

        // single read, held ready until the request drops
        mem_lat = 2;
        bus.consumer_read_address[3] = 8'h10;
        bus.consumer_read_request[3] = 1'b1;
        push(1'b1, 3, 8'h10, 8'hA5);
        step();
        check("rd_valid", 32'(bus.mem_read_valid), 1);
        check("rd_addr", 32'(bus.mem_read_address), 32'h10);
        check("rd_busy", 32'(busy), 1);
        wait_ready("rd_ready3", 3, 1'b1, 20);
        for (int k = 0; k < 3; k++) begin
            step();
            check("rd_ready3_hold", 32'(bus.consumer_read_ready[3]), 1);
        end
        bus.consumer_read_request[3] = 1'b0;
        step();
        check("rd_ready3_clear", 32'(bus.consumer_read_ready[3]), 0);
        check("rd_idle", 32'(busy), 0);
        check("rd_data3_held", 32'(bus.consumer_read_data[3]), 32'hA5);

        // single write, no read traffic
        mem_lat = 1;
        rc = rd_count;
        bus.consumer_write_address[0] = 8'h22;
        bus.consumer_write_data[0]    = 8'h7E;
        bus.consumer_write_request[0] = 1'b1;
        push(1'b0, 0, 8'h22, 8'h7E);
        step();
        check("wr_valid", 32'(bus.mem_write_valid), 1);
        check("wr_addr", 32'(bus.mem_write_address), 32'h22);
        check("wr_data", 32'(bus.mem_write_data), 32'h7E);
        check("wr_no_read", 32'(bus.mem_read_valid), 0);
        run_until_idle("wr", 50);
        check("wr_no_read_count", rd_count, rc);
        check("wr_mem", 32'(mem[8'h22]), 32'h7E);

        // fairness: all eight read from rr_ptr=0; consumer 0 re-requests after service
        do_reset();
        for (int i = 0; i < N; i++) begin
            bus.consumer_read_address[i] = 8'(8'h40 + i);
            bus.consumer_read_request[i] = 1'b1;
            push(1'b1, i, 8'(8'h40 + i), 8'(8'h80 + i));
        end
        push(1'b1, 0, 8'h48, 8'h88);
        rearmed = 1'b0;
        rearm_pending = 1'b0;
        n = 0;
        do begin
            step_auto(d);
            n++;
            if (rearm_pending) begin
                bus.consumer_read_address[0] = 8'h48;
                bus.consumer_read_request[0] = 1'b1;
                rearm_pending = 1'b0;
                rearmed = 1'b1;
            end else if (!rearmed && d[0]) begin
                rearm_pending = 1'b1;
            end
        end while (!(rearmed && all_quiet()) && n < 400);
        check("fair_done", 32'(rearmed && all_quiet()), 1);

        // wrap: put rr_ptr at 7 by serving consumer 6, then 7 and 1 together
        bus.consumer_read_address[6] = 8'h66;
        bus.consumer_read_request[6] = 1'b1;
        push(1'b1, 6, 8'h66, 8'h99);
        run_until_idle("wrap_pre", 50);
        bus.consumer_read_address[7] = 8'h67;
        bus.consumer_read_address[1] = 8'h61;
        bus.consumer_read_request[7] = 1'b1;
        bus.consumer_read_request[1] = 1'b1;
        push(1'b1, 7, 8'h67, 8'h98);
        push(1'b1, 1, 8'h61, 8'h9E);
        run_until_idle("wrap", 100);
        // rr_ptr now 2: consumer 2 must beat consumer 0
        bus.consumer_read_address[0] = 8'h60;
        bus.consumer_read_address[2] = 8'h62;
        bus.consumer_read_request[0] = 1'b1;
        bus.consumer_read_request[2] = 1'b1;
        push(1'b1, 2, 8'h62, 8'h9D);
        push(1'b1, 0, 8'h60, 8'h9F);
        run_until_idle("wrap_ptr", 100);

        // read/write collision on consumer 2
        bus.consumer_read_address[2]  = 8'h30;
        bus.consumer_write_address[2] = 8'h31;
        bus.consumer_write_data[2]    = 8'h5C;
        bus.consumer_read_request[2]  = 1'b1;
        bus.consumer_write_request[2] = 1'b1;
        push(1'b1, 2, 8'h30, 8'hCF);
        push(1'b0, 2, 8'h31, 8'h5C);
        run_until_idle("coll", 100);
        check("coll_mem", 32'(mem[8'h31]), 32'h5C);

        // request dropped while waiting on memory: one-cycle ready pulse
        mem_lat = 4;
        bus.consumer_read_address[4] = 8'h44;
        bus.consumer_read_request[4] = 1'b1;
        push(1'b1, 4, 8'h44, 8'h84);
        step();
        check("drop_valid", 32'(bus.mem_read_valid), 1);
        bus.consumer_read_request[4] = 1'b0;
        wait_ready("drop_ready4", 4, 1'b1, 20);
        step();
        check("drop_pulse_end", 32'(bus.consumer_read_ready[4]), 0);
        check("drop_idle", 32'(busy), 0);

        // reset during READ_WAIT, then grant order restarts at consumer 0
        mem_lat = 10;
        bus.consumer_read_address[5] = 8'h70;
        bus.consumer_read_request[5] = 1'b1;
        step();
        step();
        check("mid_valid", 32'(bus.mem_read_valid), 1);
        reset = 1'b1;
        bus.consumer_read_request[5] = 1'b0;
        step();
        check("mid_rst_valid", 32'(bus.mem_read_valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_ready", 32'({bus.consumer_read_ready, bus.consumer_write_ready}), 0);
        check("mid_rst_data", 32'(|bus.consumer_read_data), 0);
        reset = 1'b0;
        step();
        check("mid_post_busy", 32'(busy), 0);
        mem_lat = 2;
        bus.consumer_read_address[1] = 8'h71;
        bus.consumer_read_address[6] = 8'h76;
        bus.consumer_read_request[1] = 1'b1;
        bus.consumer_read_request[6] = 1'b1;
        push(1'b1, 1, 8'h71, 8'h8E);
        push(1'b1, 6, 8'h76, 8'h89);
        run_until_idle("post_rst", 100);

        step();
        step();
        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
